regfile_wb_scheduler: RTL and testbench

- Shares the register file's single write port (RegWrite / Write_register / Write_data) between two requesters.
  - Requester A: main-pipeline writeback. Fixed priority, never back-pressured.
  - Requester B: long-latency units (mult/div, slow loads). Valid/ready handshake into a small holding FIFO.
- Also keeps a 32-bit busy scoreboard of registers with outstanding B results, and reports RAW/WAW hazards to the hazard unit.
- Sits between the writeback stage and the register file.

---
 rtl/regfile_wb_scheduler_pkg.sv | 13 +
 rtl/regfile_wb_scheduler_wb_fifo.sv | 55 +++++
 rtl/regfile_wb_scheduler.sv | 111 +++++++++++
 tb/tb_regfile_wb_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared types and constants for the register-file writeback scheduler.
package regfile_wb_scheduler_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_scheduler_wb_fifo.sv
// Small holding FIFO for long-latency writeback results.
module wb_fifo
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  wb_entry_t                    push_entry,
  input  logic                         pop,
  output wb_entry_t                    head,
  output logic                         empty,
  output logic [$clog2(BUF_DEPTH):0]   count
);

  localparam int PW = $clog2(BUF_DEPTH);

  wb_entry_t      mem [BUF_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           full;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (PW+1)'(BUF_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the register-file write port between pipeline writeback (A)
// and buffered long-latency results (B); tracks busy registers for hazards.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int BUF_DEPTH = 2,
  parameter int MAX_WAIT  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [REG_AW-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [REG_AW-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_reg,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  output logic              hazard_rs,
  output logic              hazard_rt,
  output logic              hazard_rd,
  output logic              a_stall,
  output logic              RegWrite,
  output logic [REG_AW-1:0] Write_register,
  output logic [DATA_W-1:0] Write_data
);

  localparam int CNT_W  = $clog2(BUF_DEPTH) + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  wb_entry_t          fifo_head;
  wb_entry_t          push_entry;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               a_win;
  logic               b_push;
  logic               b_pop;
  logic [31:0]        busy;
  logic [31:0]        busy_next;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [WAIT_W-1:0]  wait_next;

  assign b_ready    = (fifo_count < CNT_W'(BUF_DEPTH));
  assign b_push     = b_valid && b_ready && (b_reg != REG_ZERO);
  assign a_win      = a_valid && (a_reg != REG_ZERO);
  assign b_pop      = !a_win && !fifo_empty;
  assign push_entry = '{dest: b_reg, data: b_data};

  wb_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (b_push),
    .push_entry (push_entry),
    .pop        (b_pop),
    .head       (fifo_head),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  always_comb begin
    RegWrite       = 1'b0;
    Write_register = REG_ZERO;
    Write_data     = '0;
    if (a_win) begin
      RegWrite       = 1'b1;
      Write_register = a_reg;
      Write_data     = a_data;
    end else if (b_pop) begin
      RegWrite       = 1'b1;
      Write_register = fifo_head.dest;
      Write_data     = fifo_head.data;
    end
  end

  // A newer issue to the same register outlives the retiring result.
  always_comb begin
    busy_next = busy;
    if (b_pop) busy_next[fifo_head.dest] = 1'b0;
    if (issue_valid && (issue_reg != REG_ZERO)) busy_next[issue_reg] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    wait_next = wait_cnt;
    if (fifo_empty || b_pop) begin
      wait_next = '0;
    end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
      wait_next = wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      wait_cnt <= '0;
      a_stall  <= 1'b0;
    end else begin
      busy     <= busy_next;
      wait_cnt <= wait_next;
      a_stall  <= (wait_next == WAIT_W'(MAX_WAIT));
    end
  end

  assign hazard_rs = busy[rs_addr];
  assign hazard_rt = busy[rt_addr];
  assign hazard_rd = busy[issue_reg];

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench: expected writes are queued at stimulus time and a negedge
// monitor retires them against the write port.
module tb_regfile_wb_scheduler;
  import regfile_wb_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_reg;
  logic [31:0] b_data;
  logic        issue_valid;
  logic [4:0]  issue_reg;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        hazard_rs;
  logic        hazard_rt;
  logic        hazard_rd;
  logic        a_stall;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;

  int total = 0;
  int bad   = 0;
  wb_entry_t exp_q[$];
  wb_entry_t mon_e;

  always #5 clk = ~clk;

  regfile_wb_scheduler #(.BUF_DEPTH(2), .MAX_WAIT(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .a_valid        (a_valid),
    .a_reg          (a_reg),
    .a_data         (a_data),
    .b_valid        (b_valid),
    .b_ready        (b_ready),
    .b_reg          (b_reg),
    .b_data         (b_data),
    .issue_valid    (issue_valid),
    .issue_reg      (issue_reg),
    .rs_addr        (rs_addr),
    .rt_addr        (rt_addr),
    .hazard_rs      (hazard_rs),
    .hazard_rt      (hazard_rt),
    .hazard_rd      (hazard_rd),
    .a_stall        (a_stall),
    .RegWrite       (RegWrite),
    .Write_register (Write_register),
    .Write_data     (Write_data)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                               input logic bv, input logic [4:0] br, input logic [31:0] bd);
    a_valid = av;
    a_reg   = ar;
    a_data  = ad;
    b_valid = bv;
    b_reg   = br;
    b_data  = bd;
  endtask

  task automatic expectWrite(input logic [4:0] r, input logic [31:0] d);
    wb_entry_t e;
    e.dest = r;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Retire one expected write per active port cycle; idle port must be zero.
  always @(negedge clk) begin
    if (RegWrite === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_write: got reg=%0d data=0x%0h, expected no write",
                 Write_register, Write_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (Write_register !== mon_e.dest || Write_data !== mon_e.data) begin
          bad++;
          $display("[TB] FAIL write_port: got reg=%0d data=0x%0h, expected reg=%0d data=0x%0h",
                   Write_register, Write_data, mon_e.dest, mon_e.data);
        end
      end
    end else begin
      total++;
      if (RegWrite !== 1'b0 || Write_register !== 5'd0 || Write_data !== 32'd0) begin
        bad++;
        $display("[TB] FAIL idle_port: got we=%b reg=%0d data=0x%0h, expected all zero",
                 RegWrite, Write_register, Write_data);
      end
    end
    if (issue_valid === 1'b1 && reset === 1'b0) begin
      total++;
      if (hazard_rd !== 1'b0) begin
        bad++;
        $display("[TB] FAIL issue_protocol: got hazard_rd=%b on issue of r%0d, expected 0",
                 hazard_rd, issue_reg);
      end
    end
  end

  initial begin
    int guard;
    reset       = 1'b1;
    issue_valid = 1'b0;
    issue_reg   = 5'd0;
    rs_addr     = 5'd0;
    rt_addr     = 5'd0;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    tick();
    reset     = 1'b0;
    rs_addr   = 5'd5;
    rt_addr   = 5'd9;
    issue_reg = 5'd3;
    settle();
    checkOutput("reset_regwrite", RegWrite, 0);
    checkOutput("reset_b_ready", b_ready, 1);
    checkOutput("reset_hazard_rs", hazard_rs, 0);
    checkOutput("reset_hazard_rt", hazard_rt, 0);
    checkOutput("reset_hazard_rd", hazard_rd, 0);
    checkOutput("reset_a_stall", a_stall, 0);

    // Scoreboard lifetime of a long-latency result.
    tick();
    issue_valid = 1'b1;
    issue_reg   = 5'd5;
    tick();
    issue_valid = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    expectWrite(5'd5, 32'hDEADBEEF);
    settle();
    checkOutput("busy_rs_at_t", hazard_rs, 1);
    checkOutput("busy_rd_at_t", hazard_rd, 1);
    checkOutput("no_bypass", RegWrite, 0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    settle();
    checkOutput("busy_rs_at_t1", hazard_rs, 1);
    checkOutput("b_write_at_t1", Write_register, 5);
    tick();
    settle();
    checkOutput("busy_rs_at_t2", hazard_rs, 0);

    // A beats a queued B.
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h22);
    settle();
    tick();
    applyStimulus(1'b1, 5'd8, 32'h11, 1'b0, 5'd0, 32'd0);
    expectWrite(5'd8, 32'h11);
    expectWrite(5'd9, 32'h22);
    settle();
    checkOutput("a_priority_reg", Write_register, 8);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    settle();
    checkOutput("b_after_a_reg", Write_register, 9);

    // Starvation guard.
    tick();
    applyStimulus(1'b1, 5'd1, 32'hA0, 1'b1, 5'd12, 32'hC0FFEE);
    expectWrite(5'd1, 32'hA0);
    settle();
    checkOutput("stall_c0", a_stall, 0);
    for (int i = 1; i <= 9; i++) begin
      tick();
      applyStimulus(1'b1, 5'd1, 32'hA0 + i, 1'b0, 5'd0, 32'd0);
      expectWrite(5'd1, 32'hA0 + i);
      settle();
      checkOutput($sformatf("stall_c%0d", i), a_stall, (i == 9) ? 1 : 0);
    end
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    expectWrite(5'd12, 32'hC0FFEE);
    settle();
    checkOutput("stall_during_drain", a_stall, 1);
    checkOutput("drain_reg", Write_register, 12);
    tick();
    settle();
    checkOutput("stall_cleared", a_stall, 0);

    // Full FIFO back-pressure.
    tick();
    applyStimulus(1'b1, 5'd2, 32'h200, 1'b1, 5'd13, 32'h13);
    expectWrite(5'd2, 32'h200);
    settle();
    checkOutput("ready_occ0", b_ready, 1);
    tick();
    applyStimulus(1'b1, 5'd2, 32'h201, 1'b1, 5'd14, 32'h14);
    expectWrite(5'd2, 32'h201);
    settle();
    checkOutput("ready_occ1", b_ready, 1);
    tick();
    applyStimulus(1'b1, 5'd2, 32'h202, 1'b1, 5'd15, 32'h15);
    expectWrite(5'd2, 32'h202);
    settle();
    checkOutput("ready_full", b_ready, 0);
    tick();
    applyStimulus(1'b1, 5'd2, 32'h203, 1'b1, 5'd15, 32'h15);
    expectWrite(5'd2, 32'h203);
    settle();
    checkOutput("ready_full_held", b_ready, 0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd15, 32'h15);
    expectWrite(5'd13, 32'h13);
    expectWrite(5'd14, 32'h14);
    expectWrite(5'd15, 32'h15);
    settle();
    checkOutput("ready_pop_cycle", b_ready, 0);
    tick();
    settle();
    checkOutput("ready_after_pop", b_ready, 1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    settle();
    checkOutput("third_written", Write_register, 15);
    tick();
    settle();
    checkOutput("fifo_drained", RegWrite, 0);

    // Writes to $0 are dropped on both sides.
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'h20);
    settle();
    tick();
    applyStimulus(1'b1, 5'd0, 32'hBAD, 1'b1, 5'd0, 32'hBAD0);
    issue_valid = 1'b1;
    issue_reg   = 5'd0;
    expectWrite(5'd20, 32'h20);
    settle();
    checkOutput("zero_b_ready", b_ready, 1);
    checkOutput("a_zero_yields", Write_register, 20);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    issue_valid = 1'b0;
    rs_addr     = 5'd0;
    rt_addr     = 5'd20;
    settle();
    checkOutput("zero_hazard_rs", hazard_rs, 0);
    checkOutput("zero_hazard_rd", hazard_rd, 0);
    checkOutput("cleared_hazard_rt", hazard_rt, 0);
    checkOutput("zero_b_ready_idle", b_ready, 1);
    tick();
    settle();
    checkOutput("zero_b_not_written", RegWrite, 0);

    // Reset while entries are queued and registers are busy.
    tick();
    issue_valid = 1'b1;
    issue_reg   = 5'd21;
    settle();
    tick();
    issue_reg = 5'd22;
    settle();
    tick();
    issue_valid = 1'b0;
    applyStimulus(1'b1, 5'd3, 32'h300, 1'b1, 5'd21, 32'h21);
    expectWrite(5'd3, 32'h300);
    settle();
    tick();
    applyStimulus(1'b1, 5'd3, 32'h301, 1'b1, 5'd22, 32'h22);
    expectWrite(5'd3, 32'h301);
    rs_addr = 5'd21;
    rt_addr = 5'd22;
    settle();
    checkOutput("pre_reset_hazard_rs", hazard_rs, 1);
    checkOutput("pre_reset_hazard_rt", hazard_rt, 1);
    tick();
    reset = 1'b1;
    applyStimulus(1'b1, 5'd3, 32'h302, 1'b0, 5'd0, 32'd0);
    expectWrite(5'd3, 32'h302);
    settle();
    checkOutput("pre_reset_full", b_ready, 0);
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    settle();
    checkOutput("post_reset_regwrite", RegWrite, 0);
    checkOutput("post_reset_b_ready", b_ready, 1);
    checkOutput("post_reset_hazard_rs", hazard_rs, 0);
    checkOutput("post_reset_hazard_rt", hazard_rt, 0);
    checkOutput("post_reset_a_stall", a_stall, 0);
    tick();
    settle();
    checkOutput("post_reset_idle", RegWrite, 0);

    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      tick();
      guard++;
    end
    checkOutput("expected_writes_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
